token_pair_decoder: RTL

- Serial receiver for the token-doubling stream: it is the decoding end of the doubling serial link.
- In a valid stream, every run of '1' tokens has even length. The block emits one output token for every received pair of '1's.
- At the end of each run it reports the decoded pair count.
- Sticky flags report two protocol faults: an odd-length run, and a run longer than 2*MAX_TOKENS.

---
 rtl/token_pair_decoder_if.sv | 33 +++
 rtl/token_pair_decoder.sv | 109 ++++++++++
 2 files changed

// File: rtl/token_pair_decoder_if.sv
// Token pair decoder bus: doubled token stream in, decoded stream and run status out.
interface token_pair_decoder_if #(
    parameter int unsigned MAX_TOKENS = 200
) ();
    localparam int unsigned PAIR_W = $clog2(MAX_TOKENS + 1);

    logic              a;
    logic              b;
    logic              run_done;
    logic [PAIR_W-1:0] run_pairs;
    logic              odd_error;
    logic              overflow;

    // Stream source / status consumer side
    modport master (
        output a,
        input  b,
        input  run_done,
        input  run_pairs,
        input  odd_error,
        input  overflow
    );

    // Decoder side
    modport slave (
        input  a,
        output b,
        output run_done,
        output run_pairs,
        output odd_error,
        output overflow
    );
endinterface

// File: rtl/token_pair_decoder.sv
// Decoding end of the token-doubling serial link: one output token per
// received pair of '1's, run-length report at the end of each run, and
// sticky flags for odd-length and over-long runs.
module token_pair_decoder #(
    parameter int unsigned MAX_TOKENS = 200
) (
    input  logic                clk,
    input  logic                rst,
    token_pair_decoder_if.slave bus
);
    localparam int unsigned PAIR_W = $clog2(MAX_TOKENS + 1);
    localparam int unsigned RUN_W  = $clog2(2 * MAX_TOKENS + 2);

    // Longest legal run; one more '1' than this is an overflow
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(2 * MAX_TOKENS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ODD  = 2'd1;
    localparam logic [1:0] ST_EVEN = 2'd2;
    localparam logic [1:0] ST_OVF  = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [RUN_W-1:0]  cnt_q,       cnt_d;
    logic              b_q,         b_d;
    logic              run_done_q,  run_done_d;
    logic [PAIR_W-1:0] run_pairs_q, run_pairs_d;
    logic              odd_error_q, odd_error_d;
    logic              overflow_q,  overflow_d;

    // State, run counter and all outputs are flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            b_q         <= 1'b0;
            run_done_q  <= 1'b0;
            run_pairs_q <= '0;
            odd_error_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            run_done_q  <= run_done_d;
            run_pairs_q <= run_pairs_d;
            odd_error_q <= odd_error_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state and next output values from the sampled stream bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = 1'b0;
        run_done_d  = 1'b0;
        run_pairs_d = run_pairs_q;
        odd_error_d = odd_error_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.a) begin
                    state_d = ST_ODD;
                    cnt_d   = RUN_W'(1);
                end
            end

            ST_ODD, ST_EVEN: begin
                if (bus.a) begin
                    if (cnt_q == RUN_LIMIT) begin
                        state_d    = ST_OVF;
                        overflow_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + RUN_W'(1);
                        state_d = (state_q == ST_ODD) ? ST_EVEN : ST_ODD;
                        // A '1' arriving in ODD completes a pair
                        b_d     = (state_q == ST_ODD);
                    end
                end else begin
                    // Run ends; a dangling odd token is dropped
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    run_done_d  = 1'b1;
                    run_pairs_d = PAIR_W'(cnt_q >> 1);
                    if (state_q == ST_ODD) begin
                        odd_error_d = 1'b1;
                    end
                end
            end

            ST_OVF: begin
                state_d = ST_OVF;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.b         = b_q;
    assign bus.run_done  = run_done_q;
    assign bus.run_pairs = run_pairs_q;
    assign bus.odd_error = odd_error_q;
    assign bus.overflow  = overflow_q;

endmodule
